// File: rtl/ks0108_panel_responder.sv
// -----------------------------------------------------------------------------
// ks0108_panel_responder
//
// Cycle-level responder for a dual-controller 128x64 KS0108-style graphic LCD.
// It watches the bus a panel driver produces, decodes instructions and data on
// the falling edge of en_i, and keeps one 512-byte display RAM per half
// (8 pages x 64 columns). A side readback port lets a bench or self-test logic
// compare the panel image against a frame buffer. Protocol violations raise a
// sticky error flag.
//
// Ports
//   clk             system clock, rising edge
//   rstn            synchronous active-low reset
//   rst_i           panel reset pin (active-low, sampled synchronously)
//   cs_i[1:0]       chip select, bit0 = left half (cols 0-63), bit1 = right
//   en_i            strobe; a transaction executes on its falling edge
//   rw_i            1 = read, 0 = write
//   dori_i          1 = data, 0 = instruction/status
//   db_i[7:0]       bus data from the driver
//   db_o[7:0]       read data toward the driver (0 when not reading)
//   db_oe_o         high while a read is in progress
//   rd_addr_i[9:0]  readback address {page[2:0], col[6:0]}
//   rd_data_o[7:0]  readback byte, one cycle after rd_addr_i
//   disp_on_o[1:0]  display-on flag per half
//   start_line_l_o  left-half start line
//   start_line_r_o  right-half start line
//   busy_o[1:0]     busy flag per half
//   err_o           sticky protocol error
//   wr_cnt_o[15:0]  accepted data-write strobes, wrapping
// -----------------------------------------------------------------------------
module ks0108_panel_responder #(
    parameter int MIN_EN_HIGH = 2,
    parameter int BUSY_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rst_i,
    input  logic [1:0]  cs_i,
    input  logic        en_i,
    input  logic        rw_i,
    input  logic        dori_i,
    input  logic [7:0]  db_i,
    output logic [7:0]  db_o,
    output logic        db_oe_o,
    input  logic [9:0]  rd_addr_i,
    output logic [7:0]  rd_data_o,
    output logic [1:0]  disp_on_o,
    output logic [5:0]  start_line_l_o,
    output logic [5:0]  start_line_r_o,
    output logic [1:0]  busy_o,
    output logic        err_o,
    output logic [15:0] wr_cnt_o
);

    localparam int EW = $clog2(MIN_EN_HIGH + 1);
    localparam int BW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [EW-1:0] EN_SAT    = EW'(MIN_EN_HIGH);
    localparam logic [BW-1:0] BUSY_LOAD = BW'(BUSY_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } half_state_t;

    // Instruction byte classes understood by the controller.
    function automatic logic is_disp(input logic [7:0] b);
        return b[7:1] == 7'b0011111;
    endfunction

    function automatic logic is_yaddr(input logic [7:0] b);
        return b[7:6] == 2'b01;
    endfunction

    function automatic logic is_page(input logic [7:0] b);
        return b[7:3] == 5'b10111;
    endfunction

    function automatic logic is_start(input logic [7:0] b);
        return b[7:6] == 2'b11;
    endfunction

    function automatic logic instr_valid(input logic [7:0] b);
        return is_disp(b) || is_yaddr(b) || is_page(b) || is_start(b);
    endfunction

    // Strobe capture: en_i registered once; en_cnt counts sampled-high cycles
    logic          en_q;
    logic [EW-1:0] en_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            en_q   <= 1'b0;
            en_cnt <= '0;
        end else begin
            en_q <= en_i;
            if (!en_i)
                en_cnt <= '0;
            else if (en_cnt != EN_SAT)
                en_cnt <= en_cnt + 1'b1;
        end
    end

    logic fall;
    logic strobe;
    logic long_enough;
    logic short_err;
    logic reading;

    assign fall        = en_q & ~en_i;
    // Deselected strobes and strobes during panel reset are simply not seen.
    assign strobe      = fall & rstn & rst_i & (|cs_i);
    assign long_enough = (en_cnt == EN_SAT);
    assign short_err   = strobe & ~long_enough;
    assign reading     = rw_i & en_i & (|cs_i);

    logic [1:0]      sel;
    logic [1:0]      busy_err;
    logic [1:0]      exec;
    logic [1:0]      bad_instr;
    logic [1:0]      data_wr;
    logic [1:0]      accept_wr;
    logic [1:0][7:0] read_byte;
    logic [1:0][7:0] rd_byte;
    logic [1:0][5:0] start_q;

    // Per-half controller: registers, busy FSM, display RAM and read latch
    for (genvar g = 0; g < 2; g++) begin : g_half
        logic [7:0]    ram [512];
        logic [2:0]    page;
        logic [5:0]    y;
        logic [5:0]    start_line;
        logic          disp_on;
        logic          reset_flag;
        logic [7:0]    rd_latch;
        half_state_t   state;
        logic [BW-1:0] busy_cnt;
        logic [8:0]    addr;
        logic          data_rd;
        logic [7:0]    status;

        assign addr = {page, y};

        // A busy half drops a write on its own; the other half still runs.
        assign sel[g]       = strobe & long_enough & cs_i[g];
        assign busy_err[g]  = sel[g] & ~rw_i & (state == ST_BUSY);
        assign exec[g]      = sel[g] & ~busy_err[g];
        assign bad_instr[g] = exec[g] & ~rw_i & ~dori_i & ~instr_valid(db_i);
        assign data_wr[g]   = exec[g] & ~rw_i & dori_i;
        assign accept_wr[g] = exec[g] & ~rw_i & ~bad_instr[g];
        assign data_rd      = exec[g] & rw_i & dori_i;

        assign status       = {state == ST_BUSY, 1'b0, ~disp_on, reset_flag, 4'b0000};
        assign read_byte[g] = dori_i ? rd_latch : status;
        assign rd_byte[g]   = ram[{rd_addr_i[9:7], rd_addr_i[5:0]}];

        assign disp_on_o[g] = disp_on;
        assign busy_o[g]    = (state == ST_BUSY);
        assign start_q[g]   = start_line;

        always_ff @(posedge clk) begin
            if (data_wr[g])
                ram[addr] <= db_i;
        end

        always_ff @(posedge clk) begin
            if (!rstn || !rst_i) begin
                disp_on    <= 1'b0;
                page       <= 3'd0;
                y          <= 6'd0;
                start_line <= 6'd0;
                state      <= ST_IDLE;
                busy_cnt   <= '0;
                reset_flag <= 1'b1;
            end else begin
                reset_flag <= 1'b0;

                case (state)
                    ST_IDLE: begin
                        if (accept_wr[g]) begin
                            state    <= ST_BUSY;
                            busy_cnt <= BUSY_LOAD;
                        end
                    end
                    ST_BUSY: begin
                        if (busy_cnt == '0)
                            state <= ST_IDLE;
                        else
                            busy_cnt <= busy_cnt - 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase

                if (exec[g] && !rw_i) begin
                    if (dori_i)
                        y <= y + 1'b1;
                    else if (is_disp(db_i))
                        disp_on <= db_i[0];
                    else if (is_yaddr(db_i))
                        y <= db_i[5:0];
                    else if (is_page(db_i))
                        page <= db_i[2:0];
                    else if (is_start(db_i))
                        start_line <= db_i[5:0];
                end else if (data_rd) begin
                    y <= y + 1'b1;
                end
            end
        end

        // The latch is what the next data read returns, so the first read
        // after an address change hands back stale contents.
        always_ff @(posedge clk) begin
            if (!rstn)
                rd_latch <= 8'h00;
            else if (data_rd)
                rd_latch <= ram[addr];
        end
    end

    assign start_line_l_o = start_q[0];
    assign start_line_r_o = start_q[1];

    // Shared outputs: error flag, write counter, read bus and readback port
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_o     <= 1'b0;
            wr_cnt_o  <= 16'd0;
            db_o      <= 8'h00;
            db_oe_o   <= 1'b0;
            rd_data_o <= 8'h00;
        end else begin
            if (short_err || (|busy_err) || (|bad_instr))
                err_o <= 1'b1;
            // One count per strobe even when both halves take the byte.
            if (|data_wr)
                wr_cnt_o <= wr_cnt_o + 16'd1;
            db_oe_o   <= reading;
            // Left half wins the bus when both are selected.
            db_o      <= reading ? (cs_i[0] ? read_byte[0] : read_byte[1]) : 8'h00;
            rd_data_o <= rd_byte[rd_addr_i[6]];
        end
    end

endmodule
